exu_dmem_resp: RTL and testbench
================================

# exu_dmem_resp

Data-memory responder on the execute-stage memory port. It accepts the load/store requests issued by the execute stage (write/read enable, address, write data, access size) and services them against an internal word-organised RAM, with a configurable wait-state count. It returns read data with sign or zero extension, drives a busy signal that stalls the core while a request is in flight, and reports misaligned, out-of-range and illegal requests.

## Interface
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words (power of two).
- `BASE_ADDR`, default 32'h8000_0000: byte address of word 0.
- `WAIT_CYCLES`, default 1: wait states inserted before the response (0–15).

Ports:
- `clk` in 1: single clock; all state is updated on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_mem_wen` in 1: store request.
- `i_mem_ren` in 1: load request.
- `i_mem_addr` in 32: byte address.
- `i_mem_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `i_mem_size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `i_mem_unsigned` in 1: zero-extend load data (LBU/LHU) instead of sign-extending.
- `o_busy` out 1: request in flight; the core stalls while this is high.
- `o_done` out 1: one-cycle pulse that completes the request.
- `o_rdata` out 32: load result, valid when `o_done` is high and the request was a load.
- `o_err` out 1: valid with `o_done`; the request was faulted and had no memory side effect.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **Acceptance.** In IDLE, a request is accepted when `i_mem_wen | i_mem_ren` is high. On acceptance the block latches addr, wdata, size, unsigned and the request type.
- **IDLE transitions.** The FSM moves to WAIT with the wait counter loaded to `WAIT_CYCLES-1`. If `WAIT_CYCLES == 0`, it moves directly to RESP.
- **WAIT.** The counter decrements each cycle. At 0 the FSM moves to RESP.
- **RESP.** `o_done` = 1 for exactly one cycle, then the FSM returns to IDLE. A new request is accepted no earlier than the cycle after RESP.
- **Busy.** `o_busy` = 1 in WAIT and RESP.
- **Fault checks** are evaluated at acceptance. Any one of the following sets `o_err` in RESP:
  - `wen & ren` both high;
  - size == 11;
  - half access with addr[0] = 1;
  - word access with addr[1:0] ≠ 0;
  - (addr − BASE_ADDR) ≥ `DEPTH_WORDS*4`.
- **Faulted requests** do not write the RAM and return `o_rdata` = 0.
- **Store.** The RAM is written on the clock edge that leaves RESP. Only the byte lanes selected by size and addr[1:0] are written, using the byte-enable strobe:
  - byte: 4'b0001 << addr[1:0];
  - half: 4'b0011 << addr[1:0];
  - word: 4'b1111.
  - Write data is replicated across lanes before the strobe is applied.
- **Load.** The word index is (addr − BASE_ADDR)[log2(DEPTH)+1:2]. The selected byte or half is shifted down by addr[1:0] and extended to 32 bits: zero-extended if `i_mem_unsigned`, sign-extended otherwise. Word loads ignore `i_mem_unsigned`.
- **Read-after-write.** A load accepted after a store's `o_done` returns the stored data.
- **Reset.** Reset forces IDLE and clears the counter and all latched request fields. An in-flight store is dropped; it has not been committed, because the commit happens on leaving RESP. RAM contents are not reset.

## Timing
- **Reset values:** `o_busy` = 0, `o_done` = 0, `o_rdata` = 0, `o_err` = 0.
- **Latency:** request accepted at cycle N, then `o_done` at cycle N+1+`WAIT_CYCLES`.
- **Throughput:** one request per 2+`WAIT_CYCLES` cycles.
- **Registered outputs:** `o_rdata` and `o_err` are registered and held stable during RESP. They return to 0 in the following cycle.
- **Input stability:** request inputs are ignored while `o_busy` = 1. The core may hold them or change them without effect.
- **Reset priority:** reset asserted in any cycle wins over all FSM activity in that cycle.

## Structure
- Shared package `dmem_pkg` holds:
  - size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`);
  - FSM state enum (IDLE/WAIT/RESP);
  - wait-counter width constant (4).
- One combinational sub-module, `dmem_lane_fmt`:
  - inputs: size, addr[1:0], unsigned, wdata, raw RAM word;
  - outputs: byte strobe, replicated write data, extended load data, misalign flag.
- The RAM is an internal reg array with per-byte write enables, readable asynchronously from latched state.

## Test plan
- **Word store then load.** Store 32'hDEAD_BEEF at 32'h8000_0010 (`WAIT_CYCLES` = 1), then load word from the same address. Required: `o_done` at N+2 each time, `o_rdata` = 32'hDEAD_BEEF, `o_err` = 0.
- **Byte loads with extension.** Preload word 32'h80FF_7F01 at 32'h8000_0020.
  - LB at +1 → 32'h0000_007F.
  - LB at +3 → 32'hFFFF_FF80.
  - LBU at +2 → 32'h0000_00FF.
- **Half store lane select.** SH of 16'h1234 at 32'h8000_0022 over 32'hAAAA_AAAA. Required: word reads back 32'h1234_AAAA, strobe = 4'b1100. LH at +2 returns 32'h0000_1234.
- **Faults.**
  - word load at 32'h8000_0002 → `o_err` = 1, `o_rdata` = 0;
  - store at BASE + DEPTH*4 → `o_err` = 1, RAM unchanged;
  - `wen` = `ren` = 1 → `o_err` = 1.
- **Reset mid-store.** Assert `rst` during WAIT of a store of 32'h5555_5555 over 32'h0. Required: outputs return to 0, FSM is in IDLE, and a subsequent load reads 32'h0.
- **Back-to-back and zero wait.** With `WAIT_CYCLES` = 0, issue continuous requests with wen held high. Required: a `o_done` every 2 cycles, `o_busy` pattern 0,1,0,1…, and inputs presented while busy are ignored.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the execute-stage data-memory responder:
// access-size encodings, FSM state type and wait-counter width.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int unsigned WCNT_W = 4;

  typedef logic [WCNT_W-1:0] wcnt_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter for the data-memory responder (purely combinational).
//   i_size       : access size (byte/half/word/illegal)
//   i_addr_lo    : byte offset within the word
//   i_unsigned   : zero-extend loads instead of sign-extending
//   i_wdata      : right-aligned store data
//   i_rword      : raw RAM word at the addressed index
//   o_strb       : per-byte write strobe
//   o_wdata_rep  : store data replicated across all lanes
//   o_rdata_ext  : selected lane shifted down and extended to 32 bits
//   o_misalign   : half/word access not naturally aligned
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_strb,
  output logic [31:0] o_wdata_rep,
  output logic [31:0] o_rdata_ext,
  output logic        o_misalign
);

  logic [31:0] shifted;

  always_comb begin
    shifted     = i_rword >> {i_addr_lo, 3'b000};
    o_strb      = '0;
    o_wdata_rep = '0;
    o_rdata_ext = '0;
    o_misalign  = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_strb      = 4'b0001 << i_addr_lo;
        o_wdata_rep = {4{i_wdata[7:0]}};
        o_rdata_ext = i_unsigned ? {24'b0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        o_strb      = 4'b0011 << i_addr_lo;
        o_wdata_rep = {2{i_wdata[15:0]}};
        o_rdata_ext = i_unsigned ? {16'b0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
        o_misalign  = i_addr_lo[0];
      end
      SZ_WORD: begin
        o_strb      = 4'b1111;
        o_wdata_rep = i_wdata;
        o_rdata_ext = i_rword;
        o_misalign  = |i_addr_lo;
      end
      default: begin
        o_strb      = '0;
        o_wdata_rep = '0;
        o_rdata_ext = '0;
        o_misalign  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/exu_dmem_resp.sv
// Execute-stage data-memory responder. Accepts one load/store at a time,
// services it against an internal word RAM after WAIT_CYCLES wait states,
// and returns extended load data or a fault indication with a one-cycle
// o_done pulse.
//   clk, rst        : clock, synchronous active-high reset
//   i_mem_wen/ren   : store / load request
//   i_mem_addr      : byte address
//   i_mem_wdata     : right-aligned store data
//   i_mem_size      : 00 byte, 01 half, 10 word, 11 illegal
//   i_mem_unsigned  : zero-extend byte/half loads
//   o_busy          : request in flight (WAIT or RESP)
//   o_done          : completion pulse
//   o_rdata         : load result, valid with o_done
//   o_err           : request faulted, valid with o_done
module exu_dmem_resp
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mem_wen,
  input  logic        i_mem_ren,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [1:0]  i_mem_size,
  input  logic        i_mem_unsigned,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

  state_e      state_q, state_d;
  wcnt_t       cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        wen_q, wen_d;
  logic        ren_q, ren_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // In IDLE the request is still on the inputs; afterwards it lives in the
  // latched fields. Muxing here lets one formatter and one fault check serve
  // both the zero-wait case (respond straight from acceptance) and the
  // RESP-cycle commit.
  logic        idle;
  logic [31:0] cur_addr, cur_wdata;
  logic [1:0]  cur_size;
  logic        cur_uns, cur_wen, cur_ren;
  logic [31:0] off;
  logic [IDX_W-1:0] idx;
  logic [31:0] rword;
  logic [3:0]  strb;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;
  logic        misalign;
  logic        fault;
  logic        mem_we;

  always_comb begin
    idle      = (state_q == S_IDLE);
    cur_addr  = idle ? i_mem_addr     : addr_q;
    cur_wdata = idle ? i_mem_wdata    : wdata_q;
    cur_size  = idle ? i_mem_size     : size_q;
    cur_uns   = idle ? i_mem_unsigned : uns_q;
    cur_wen   = idle ? i_mem_wen      : wen_q;
    cur_ren   = idle ? i_mem_ren      : ren_q;
    off       = cur_addr - BASE_ADDR;
    idx       = off[IDX_W+1:2];
    rword     = mem[idx];
  end

  dmem_lane_fmt u_lane_fmt (
    .i_size      (cur_size),
    .i_addr_lo   (cur_addr[1:0]),
    .i_unsigned  (cur_uns),
    .i_wdata     (cur_wdata),
    .i_rword     (rword),
    .o_strb      (strb),
    .o_wdata_rep (wdata_rep),
    .o_rdata_ext (rdata_ext),
    .o_misalign  (misalign)
  );

  always_comb begin
    fault = (cur_wen & cur_ren) | (cur_size == SZ_ILL) | misalign |
            ({1'b0, off} >= SPAN);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wen_d   = wen_q;
    ren_d   = ren_q;
    rdata_d = '0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_mem_wen | i_mem_ren) begin
          addr_d  = i_mem_addr;
          wdata_d = i_mem_wdata;
          size_d  = i_mem_size;
          uns_d   = i_mem_unsigned;
          wen_d   = i_mem_wen;
          ren_d   = i_mem_ren;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = wcnt_t'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - wcnt_t'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Response registers load only on entry to RESP so they hold for the
    // whole RESP cycle and fall back to zero right after.
    if ((state_d == S_RESP) && (state_q != S_RESP)) begin
      err_d   = fault;
      rdata_d = (cur_ren && !fault) ? rdata_ext : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Stores commit on the edge leaving RESP; reset in that cycle drops them.
  always_comb begin
    mem_we = (state_q == S_RESP) && wen_q && !fault && !rst;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (strb[b]) begin
          mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    o_busy  = (state_q != S_IDLE);
    o_done  = (state_q == S_RESP);
    o_rdata = rdata_q;
    o_err   = err_q;
  end

endmodule

// File: tb/tb_exu_dmem_resp.sv
module tb_exu_dmem_resp;
  import dmem_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut1: one wait state; dut0: zero wait states
  logic        wen1 = 0, ren1 = 0, uns1 = 0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic [1:0]  size1 = '0;
  logic        busy1, done1, err1;
  logic [31:0] rdata1;

  logic        wen0 = 0, ren0 = 0, uns0 = 0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [1:0]  size0 = '0;
  logic        busy0, done0, err0;
  logic [31:0] rdata0;

  exu_dmem_resp #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .i_mem_wen(wen1), .i_mem_ren(ren1),
    .i_mem_addr(addr1), .i_mem_wdata(wdata1), .i_mem_size(size1),
    .i_mem_unsigned(uns1), .o_busy(busy1), .o_done(done1),
    .o_rdata(rdata1), .o_err(err1)
  );

  exu_dmem_resp #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .i_mem_wen(wen0), .i_mem_ren(ren0),
    .i_mem_addr(addr0), .i_mem_wdata(wdata0), .i_mem_size(size0),
    .i_mem_unsigned(uns0), .o_busy(busy0), .o_done(done0),
    .o_rdata(rdata0), .o_err(err0)
  );

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  int unsigned cyc = 0;
  exp_t q1[$];
  exp_t q0[$];
  logic prev_done1 = 1'b0;
  logic prev_done0 = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_done1 = 1'b0;
    end else begin
      if (prev_done1) begin
        chk("rdata_clr1", rdata1, 32'h0);
        chk("err_clr1", {31'b0, err1}, 32'h0);
      end
      if (done1) begin
        chk("busy_at_done1", {31'b0, busy1}, 32'h1);
        if (q1.size() == 0) begin
          chk("spurious_done1", {31'b0, done1}, 32'h0);
        end else begin
          e = q1.pop_front();
          chk("rdata1", rdata1, e.rdata);
          chk("err1", {31'b0, err1}, {31'b0, e.err});
          chk("latency1", cyc, e.done_cyc);
        end
      end
      prev_done1 = done1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_done0 = 1'b0;
    end else begin
      if (prev_done0) begin
        chk("rdata_clr0", rdata0, 32'h0);
        chk("err_clr0", {31'b0, err0}, 32'h0);
      end
      if (done0) begin
        if (q0.size() == 0) begin
          chk("spurious_done0", {31'b0, done0}, 32'h0);
        end else begin
          e = q0.pop_front();
          chk("rdata0", rdata0, e.rdata);
          chk("err0", {31'b0, err0}, {31'b0, e.err});
          chk("latency0", cyc, e.done_cyc);
        end
      end
      prev_done0 = done0;
    end
  end

  // z selects the zero-wait instance. Holds the request for its acceptance
  // cycle only, then waits (bounded) for the scoreboard entry to drain.
  task automatic issue(input bit z, input logic wen, input logic ren,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int unsigned n;
    @(negedge clk);
    n = 0;
    while ((z ? busy0 : busy1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (z) begin
      wen0 = wen; ren0 = ren; addr0 = addr; wdata0 = wdata; size0 = size; uns0 = uns;
    end else begin
      wen1 = wen; ren1 = ren; addr1 = addr; wdata1 = wdata; size1 = size; uns1 = uns;
    end
    e.rdata = exp_rd;
    e.err = exp_err;
    e.done_cyc = cyc + (z ? 1 : 2);
    if (z) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    if (z) begin wen0 = 0; ren0 = 0; end else begin wen1 = 0; ren1 = 0; end
    n = 0;
    while ((z ? q0.size() : q1.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if ((z ? q0.size() : q1.size()) != 0) begin
      chk("done_timeout", z ? q0.size() : q1.size(), 32'h0);
      if (z) q0.delete(); else q1.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy1}, 32'h0);
    chk("rst_done", {31'b0, done1}, 32'h0);
    chk("rst_rdata", rdata1, 32'h0);
    chk("rst_err", {31'b0, err1}, 32'h0);
    chk("rst_busy0", {31'b0, busy0}, 32'h0);
    rst = 1'b0;

    // word store then load
    issue(0, 1, 0, BASE + 32'h10, 32'hDEAD_BEEF, SZ_WORD, 0, 32'h0, 0);
    issue(0, 0, 1, BASE + 32'h10, 32'h0, SZ_WORD, 0, 32'hDEAD_BEEF, 0);

    // byte/half loads with extension
    issue(0, 1, 0, BASE + 32'h20, 32'h80FF_7F01, SZ_WORD, 0, 32'h0, 0);
    issue(0, 0, 1, BASE + 32'h21, 32'h0, SZ_BYTE, 0, 32'h0000_007F, 0);
    issue(0, 0, 1, BASE + 32'h23, 32'h0, SZ_BYTE, 0, 32'hFFFF_FF80, 0);
    issue(0, 0, 1, BASE + 32'h22, 32'h0, SZ_BYTE, 1, 32'h0000_00FF, 0);
    issue(0, 0, 1, BASE + 32'h20, 32'h0, SZ_HALF, 0, 32'h0000_7F01, 0);
    issue(0, 0, 1, BASE + 32'h22, 32'h0, SZ_HALF, 1, 32'h0000_80FF, 0);
    issue(0, 0, 1, BASE + 32'h22, 32'h0, SZ_HALF, 0, 32'hFFFF_80FF, 0);
    issue(0, 0, 1, BASE + 32'h20, 32'h0, SZ_WORD, 1, 32'h80FF_7F01, 0);

    // half / byte store lane select
    issue(0, 1, 0, BASE + 32'h20, 32'hAAAA_AAAA, SZ_WORD, 0, 32'h0, 0);
    issue(0, 1, 0, BASE + 32'h22, 32'hFFFF_1234, SZ_HALF, 0, 32'h0, 0);
    issue(0, 0, 1, BASE + 32'h20, 32'h0, SZ_WORD, 0, 32'h1234_AAAA, 0);
    issue(0, 0, 1, BASE + 32'h22, 32'h0, SZ_HALF, 0, 32'h0000_1234, 0);
    issue(0, 1, 0, BASE + 32'h21, 32'h0000_005A, SZ_BYTE, 0, 32'h0, 0);
    issue(0, 0, 1, BASE + 32'h20, 32'h0, SZ_WORD, 0, 32'h1234_5AAA, 0);

    // faults
    issue(0, 1, 0, BASE, 32'hCAFE_F00D, SZ_WORD, 0, 32'h0, 0);
    issue(0, 0, 1, BASE + 32'h2, 32'h0, SZ_WORD, 0, 32'h0, 1);
    issue(0, 1, 0, BASE + 32'd4096, 32'h1111_1111, SZ_WORD, 0, 32'h0, 1);
    issue(0, 0, 1, BASE, 32'h0, SZ_WORD, 0, 32'hCAFE_F00D, 0);
    issue(0, 1, 1, BASE + 32'h10, 32'h2222_2222, SZ_WORD, 0, 32'h0, 1);
    issue(0, 0, 1, BASE + 32'h10, 32'h0, SZ_ILL, 0, 32'h0, 1);
    issue(0, 0, 1, BASE + 32'h11, 32'h0, SZ_HALF, 0, 32'h0, 1);
    issue(0, 1, 0, BASE + 32'h13, 32'h3333_3333, SZ_HALF, 0, 32'h0, 1);
    issue(0, 0, 1, BASE - 32'h4, 32'h0, SZ_WORD, 0, 32'h0, 1);
    issue(0, 0, 1, BASE + 32'h10, 32'h0, SZ_WORD, 0, 32'hDEAD_BEEF, 0);

    // reset during WAIT of a store drops it
    issue(0, 1, 0, BASE + 32'h40, 32'h0, SZ_WORD, 0, 32'h0, 0);
    @(negedge clk);
    wen1 = 1; addr1 = BASE + 32'h40; wdata1 = 32'h5555_5555; size1 = SZ_WORD;
    @(negedge clk);
    chk("wait_busy", {31'b0, busy1}, 32'h1);
    wen1 = 0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {31'b0, busy1}, 32'h0);
    chk("mid_rst_done", {31'b0, done1}, 32'h0);
    chk("mid_rst_rdata", rdata1, 32'h0);
    chk("mid_rst_err", {31'b0, err1}, 32'h0);
    rst = 1'b0;
    issue(0, 0, 1, BASE + 32'h40, 32'h0, SZ_WORD, 0, 32'h0, 0);

    // zero wait: preload, then back-to-back stores with wen held high
    for (int k = 0; k < 10; k++)
      issue(1, 1, 0, BASE + 32'h100 + 32'(4*k), 32'hFFFF_0000 + 32'(k), SZ_WORD, 0, 32'h0, 0);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      exp_t e;
      chk("b2b_busy", {31'b0, busy0}, 32'(k % 2));
      chk("b2b_done", {31'b0, done0}, 32'(k % 2));
      wen0 = 1; ren0 = 0; size0 = SZ_WORD;
      addr0 = BASE + 32'h100 + 32'(4*k);
      wdata0 = 32'h1000_0000 + 32'(k);
      if (k % 2 == 0) begin
        e.rdata = 32'h0; e.err = 1'b0; e.done_cyc = cyc + 1;
        q0.push_back(e);
      end
      @(negedge clk);
    end
    wen0 = 0;
    repeat (3) @(negedge clk);
    chk("b2b_drain", q0.size(), 32'h0);
    q0.delete();
    for (int k = 0; k < 10; k++)
      issue(1, 0, 1, BASE + 32'h100 + 32'(4*k), 32'h0, SZ_WORD, 0,
            (k % 2 == 0) ? 32'h1000_0000 + 32'(k) : 32'hFFFF_0000 + 32'(k), 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
